fb_write_ctrl: RTL

FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

---
 rtl/fb_ctrl_pkg.sv | 31 +++
 rtl/fb_write_ctrl_if.sv | 21 ++
 rtl/fb_addr_gen.sv | 34 +++
 rtl/fb_write_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fb_ctrl_pkg.sv
// Shared constants, command codes and FSM encoding for the framebuffer write controller.
package fb_ctrl_pkg;

  localparam int FB_BYTES = 8000;
  localparam int ADDR_W   = 13;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_SWAP  = 8'h02;
  localparam logic [7:0] CMD_CLEAR = 8'h03;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR_HI   = 3'd1,
    ADDR_LO   = 3'd2,
    LEN_HI    = 3'd3,
    LEN_LO    = 3'd4,
    DATA      = 3'd5,
    WAIT_SWAP = 3'd6
  } fsm_state_t;

  // Increment an address, returning to zero after the last framebuffer byte.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] addr,
                                                 input logic [ADDR_W-1:0] last);
    if (addr == last) begin
      return {ADDR_W{1'b0}};
    end else begin
      return addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/fb_write_ctrl_if.sv
// Received-byte stream and framebuffer write port of the controller.
interface fb_write_ctrl_if;

  logic                          rx_valid;
  logic [7:0]                    rx_data;
  logic                          rx_ready;
  logic                          fb_we;
  logic [fb_ctrl_pkg::ADDR_W-1:0] fb_waddr;
  logic [7:0]                    fb_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, fb_we, fb_waddr, fb_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, fb_we, fb_waddr, fb_wdata
  );

endinterface

// File: rtl/fb_addr_gen.sv
// Framebuffer write address counter: load a start address, then step with wrap at FB_BYTES.
module fb_addr_gen
  import fb_ctrl_pkg::ADDR_W, fb_ctrl_pkg::wrap_inc;
#(
  parameter int FB_BYTES = fb_ctrl_pkg::FB_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BYTES - 1);

  logic [ADDR_W-1:0] addr_r;

  // Address register: load has priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r <= {ADDR_W{1'b0}};
    end else if (load) begin
      addr_r <= load_addr;
    end else if (inc) begin
      addr_r <= wrap_inc(addr_r, LAST_ADDR);
    end else begin
      addr_r <= addr_r;
    end
  end

  assign addr = addr_r;

endmodule

// File: rtl/fb_write_ctrl.sv
// Command decoder turning a received byte stream into framebuffer writes and
// frame-synchronised buffer swaps.
module fb_write_ctrl
  import fb_ctrl_pkg::ADDR_W, fb_ctrl_pkg::fsm_state_t,
         fb_ctrl_pkg::IDLE, fb_ctrl_pkg::ADDR_HI, fb_ctrl_pkg::ADDR_LO,
         fb_ctrl_pkg::LEN_HI, fb_ctrl_pkg::LEN_LO, fb_ctrl_pkg::DATA,
         fb_ctrl_pkg::WAIT_SWAP, fb_ctrl_pkg::CMD_WRITE,
         fb_ctrl_pkg::CMD_SWAP, fb_ctrl_pkg::CMD_CLEAR;
#(
  parameter int FB_BYTES = fb_ctrl_pkg::FB_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  fb_write_ctrl_if.slave        bus,
  input  logic                  frame_sync,
  output logic                  fb_switch,
  output logic                  swap_pending,
  output logic                  overrun,
  output logic                  cmd_err
);

  localparam logic [15:0] FB_LIMIT = 16'(FB_BYTES);

  fsm_state_t        state_r;
  logic              rx_ready_r;
  logic              fb_we_r;
  logic [ADDR_W-1:0] fb_waddr_r;
  logic [7:0]        fb_wdata_r;
  logic              fb_switch_r;
  logic              swap_pending_r;
  logic              overrun_r;
  logic              cmd_err_r;
  logic              range_err_r;
  logic [7:0]        addr_hi_r;
  logic [7:0]        len_hi_r;
  logic [15:0]       remain_r;

  logic              accept_s;
  logic              load_s;
  logic              inc_s;
  logic [15:0]       start_addr_s;
  logic [15:0]       len_s;
  logic [ADDR_W-1:0] cur_addr_s;

  assign accept_s     = bus.rx_valid & rx_ready_r;
  assign start_addr_s = {addr_hi_r, bus.rx_data};
  assign len_s        = {len_hi_r, bus.rx_data};
  assign load_s       = accept_s & (state_r == ADDR_LO);
  assign inc_s        = accept_s & (state_r == DATA);

  fb_addr_gen #(.FB_BYTES(FB_BYTES)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_addr (start_addr_s[ADDR_W-1:0]),
    .inc       (inc_s),
    .addr      (cur_addr_s)
  );

  // Command FSM with all outputs registered; strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      rx_ready_r     <= 1'b1;
      fb_we_r        <= 1'b0;
      fb_waddr_r     <= {ADDR_W{1'b0}};
      fb_wdata_r     <= 8'h00;
      fb_switch_r    <= 1'b0;
      swap_pending_r <= 1'b0;
      overrun_r      <= 1'b0;
      cmd_err_r      <= 1'b0;
      range_err_r    <= 1'b0;
      addr_hi_r      <= 8'h00;
      len_hi_r       <= 8'h00;
      remain_r       <= 16'd0;
    end else begin
      fb_we_r     <= 1'b0;
      fb_switch_r <= 1'b0;
      if (bus.rx_valid && !rx_ready_r) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            case (bus.rx_data)
              CMD_WRITE: state_r <= ADDR_HI;
              CMD_SWAP: begin
                state_r        <= WAIT_SWAP;
                rx_ready_r     <= 1'b0;
                swap_pending_r <= 1'b1;
              end
              CMD_CLEAR: begin
                overrun_r <= 1'b0;
                cmd_err_r <= 1'b0;
              end
              default: cmd_err_r <= 1'b1;
            endcase
          end
        end
        ADDR_HI: begin
          if (accept_s) begin
            addr_hi_r <= bus.rx_data;
            state_r   <= ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (accept_s) begin
            range_err_r <= (start_addr_s >= FB_LIMIT);
            if (start_addr_s >= FB_LIMIT) begin
              cmd_err_r <= 1'b1;
            end
            state_r <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept_s) begin
            len_hi_r <= bus.rx_data;
            state_r  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept_s) begin
            remain_r <= len_s;
            state_r  <= (len_s == 16'd0) ? IDLE : DATA;
          end
        end
        DATA: begin
          if (accept_s) begin
            // Out-of-range transfers still swallow their payload, silently.
            if (!range_err_r) begin
              fb_we_r    <= 1'b1;
              fb_waddr_r <= cur_addr_s;
              fb_wdata_r <= bus.rx_data;
            end
            remain_r <= remain_r - 16'd1;
            if (remain_r == 16'd1) begin
              state_r <= IDLE;
            end
          end
        end
        WAIT_SWAP: begin
          if (frame_sync) begin
            fb_switch_r    <= 1'b1;
            swap_pending_r <= 1'b0;
            rx_ready_r     <= 1'b1;
            state_r        <= IDLE;
          end
        end
        default: begin
          state_r        <= IDLE;
          rx_ready_r     <= 1'b1;
          swap_pending_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_ready = rx_ready_r;
  assign bus.fb_we    = fb_we_r;
  assign bus.fb_waddr = fb_waddr_r;
  assign bus.fb_wdata = fb_wdata_r;
  assign fb_switch    = fb_switch_r;
  assign swap_pending = swap_pending_r;
  assign overrun      = overrun_r;
  assign cmd_err      = cmd_err_r;

endmodule
